// File: rtl/life_ctrl_pkg.sv
// Shared constants, types and helpers for the 16x16 life array sequencer.
package life_ctrl_pkg;
  localparam int unsigned ROWS   = 16;
  localparam int unsigned COLS   = 16;
  localparam int unsigned SEL_W  = $clog2(ROWS);
  localparam int unsigned TICK_W = 24;
  localparam int unsigned GEN_W  = 16;

  typedef logic [SEL_W-1:0]  row_idx_t;
  typedef logic [COLS-1:0]   row_t;
  typedef logic [TICK_W-1:0] tick_t;
  typedef logic [GEN_W-1:0]  gen_t;

  localparam row_idx_t LAST_ROW = row_idx_t'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    STEP,
    READ
  } state_t;

  // Reload value for the inter-generation delay; a divide of 0 behaves as 1.
  function automatic tick_t tick_reload(input tick_t div);
    return (div == '0) ? '0 : div - tick_t'(1);
  endfunction
endpackage

// File: rtl/life_array_ctrl_16x16_if.sv
// Load stream, read-back stream and life array connections of the sequencer.
interface life_array_ctrl_16x16_if;
  import life_ctrl_pkg::*;

  row_t     row_data;
  logic     row_valid;
  logic     row_ready;
  row_t     out_data;
  row_idx_t out_row;
  logic     out_valid;
  logic     out_ready;
  row_t     vali;
  row_idx_t vali_selector;
  logic     write_enb;
  logic     step;
  row_idx_t valo_selector;
  row_t     valo;
  row_t     valo_prev;

  modport master (
    input  row_data, row_valid, out_ready, valo, valo_prev,
    output row_ready, out_data, out_row, out_valid,
           vali, vali_selector, write_enb, step, valo_selector
  );

  modport slave (
    output row_data, row_valid, out_ready, valo, valo_prev,
    input  row_ready, out_data, out_row, out_valid,
           vali, vali_selector, write_enb, step, valo_selector
  );
endinterface

// File: rtl/life_tick_div.sv
// Loadable down-counter; tc pulses one cycle after the count reaches zero.
module life_tick_div
  import life_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  tick_t load_val,
  output logic  tc
);
  tick_t cnt;
  logic  armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      armed <= 1'b0;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        cnt   <= load_val;
        armed <= 1'b1;
      end else if (armed) begin
        if (cnt == '0) begin
          tc    <= 1'b1;
          armed <= 1'b0;
        end else begin
          cnt <= cnt - tick_t'(1);
        end
      end
    end
  end
endmodule

// File: rtl/life_array_ctrl_16x16.sv
// Sequencer for the 16x16 life array: pattern load, timed stepping, row read-back
// and still-life detection.
module life_array_ctrl_16x16
  import life_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    load_en,
  input  gen_t                    num_gens,
  input  tick_t                   tick_div,
  input  logic                    stop,
  life_array_ctrl_16x16_if.master bus,
  output logic                    busy,
  output logic                    stable,
  output gen_t                    gen_count
);
  state_t   state;
  row_idx_t ld_idx;
  row_idx_t rd_idx;
  gen_t     num_gens_q;
  tick_t    tick_div_q;
  logic     stop_q;
  logic     changed;
  logic     tick_load;
  logic     tick_tc;

  life_tick_div u_tick (
    .clk      (clk),
    .reset    (reset),
    .load     (tick_load),
    .load_val (tick_reload(tick_div_q)),
    .tc       (tick_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      ld_idx            <= '0;
      rd_idx            <= '0;
      num_gens_q        <= '0;
      tick_div_q        <= '0;
      stop_q            <= 1'b0;
      changed           <= 1'b0;
      tick_load         <= 1'b0;
      bus.row_ready     <= 1'b0;
      bus.out_data      <= '0;
      bus.out_row       <= '0;
      bus.out_valid     <= 1'b0;
      bus.vali          <= '0;
      bus.vali_selector <= '0;
      bus.write_enb     <= 1'b0;
      bus.step          <= 1'b0;
      bus.valo_selector <= '0;
      busy              <= 1'b0;
      stable            <= 1'b0;
      gen_count         <= '0;
    end else begin
      bus.write_enb <= 1'b0;
      bus.step      <= 1'b0;
      tick_load     <= 1'b0;

      // stop is remembered only while generations are in flight
      if (stop && (state == RUN || state == STEP || state == READ)) stop_q <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            gen_count  <= '0;
            stable     <= 1'b0;
            stop_q     <= 1'b0;
            changed    <= 1'b0;
            num_gens_q <= num_gens;
            tick_div_q <= tick_div;
            busy       <= 1'b1;
            if (load_en) begin
              state         <= LOAD;
              ld_idx        <= '0;
              bus.row_ready <= 1'b1;
            end else begin
              state     <= RUN;
              tick_load <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (bus.row_valid && bus.row_ready) begin
            bus.vali          <= bus.row_data;
            bus.vali_selector <= ld_idx;
            bus.write_enb     <= 1'b1;
            ld_idx            <= ld_idx + row_idx_t'(1);
            if (ld_idx == LAST_ROW) begin
              state         <= RUN;
              bus.row_ready <= 1'b0;
              tick_load     <= 1'b1;
            end
          end
        end

        RUN: begin
          if (tick_tc) begin
            state    <= STEP;
            bus.step <= 1'b1;
          end
        end

        STEP: begin
          if (gen_count != '1) gen_count <= gen_count + gen_t'(1);
          rd_idx            <= '0;
          bus.valo_selector <= '0;
          state             <= READ;
        end

        READ: begin
          // Capture while out_valid is low: gives the selector a settle cycle
          // and a bubble between rows.
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.valo;
            bus.out_row   <= rd_idx;
            changed       <= changed | (|(bus.valo ^ bus.valo_prev));
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (rd_idx == LAST_ROW) begin
              if (!changed) begin
                stable <= 1'b1;
                state  <= IDLE;
                busy   <= 1'b0;
              end else if (stop_q || stop ||
                           (num_gens_q != '0 && gen_count == num_gens_q)) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state     <= RUN;
                changed   <= 1'b0;
                tick_load <= 1'b1;
              end
            end else begin
              rd_idx            <= rd_idx + row_idx_t'(1);
              bus.valo_selector <= rd_idx + row_idx_t'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/life_array_ctrl_16x16.md
Name: life_array_ctrl_16x16

Overview:
- Sequencer sitting directly upstream and downstream of the 16x16 life array.
- Loads an initial pattern row by row, issues single-cycle step pulses at a programmable rate, then reads back all 16 rows each generation.
- Streams the read-back rows to the display/host side over a valid/ready interface.
- Detects a still life (no cell changed in a whole generation) and stops automatically.

Parameters:
- ROWS, 16, number of array rows; also the selector range.
- COLS, 16, row width in cells.
- SEL_W, 4, selector width; must equal clog2(ROWS).
- TICK_W, 24, width of the inter-generation delay counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; honoured only in IDLE
- load_en  in  1  sampled with start; 1 = load a pattern first, 0 = run the existing array contents
- num_gens  in  16  sampled with start; number of generations to run; 0 = free-run until stop
- tick_div  in  TICK_W  sampled with start; idle cycles between generations; 0 is treated as 1
- stop  in  1  pulse; latched, then honoured at the end of the current READ
- row_data  in  COLS  load data
- row_valid  in  1  load handshake
- row_ready  out  1  load handshake
- out_data  out  COLS  read-back row
- out_row  out  SEL_W  index of out_data
- out_valid  out  1  read-back handshake
- out_ready  in  1  read-back handshake
- vali  out  COLS  to array
- vali_selector  out  SEL_W  to array
- write_enb  out  1  to array
- step  out  1  to array
- valo_selector  out  SEL_W  to array
- valo  in  COLS  from array; combinational from valo_selector
- valo_prev  in  COLS  from array
- busy  out  1  high in any state other than IDLE
- stable  out  1  set when a still life is detected
- gen_count  out  16  generations completed

Behaviour:
- Reset: state = IDLE. All outputs 0; all counters 0; stop latch cleared. Reset mid-operation aborts immediately and no further write_enb or step pulses are issued.
- States: IDLE, LOAD, RUN, STEP, READ. All outputs are registered.
- IDLE:
  - start with load_en=1 goes to LOAD; start with load_en=0 goes to RUN.
  - start clears gen_count, stable and the stop latch, and samples num_gens and tick_div.
  - start outside IDLE is ignored.
- LOAD:
  - row_ready=1. Rows are accepted in order 0..ROWS-1.
  - On a handshake, the cycle after it shows vali=row_data, vali_selector=row index and write_enb=1 for exactly one cycle.
  - The handshake for row ROWS-1 moves the state to RUN. stop is ignored in LOAD.
- RUN:
  - The tick counter counts 0..max(tick_div,1)-1, then the state moves to STEP.
- STEP:
  - step=1 for exactly one cycle; gen_count increments, saturating at 0xFFFF.
  - The state then moves to READ with rd_idx=0.
- READ:
  - valo_selector=rd_idx.
  - One cycle after the selector settles: out_valid=1, out_data=valo registered, out_row=rd_idx.
  - The per-generation changed flag is ORed with |(valo ^ valo_prev).
  - out_data, out_row and valo_selector are held stable while out_valid && !out_ready.
  - A handshake increments rd_idx. There is a one-cycle bubble before the next row, so there are never back-to-back valids.
  - Handshake on row ROWS-1:
    - changed==0: stable=1, go to IDLE.
    - Else stop latched: go to IDLE.
    - Else num_gens!=0 && gen_count==num_gens: go to IDLE.
    - Else: go to RUN, clearing changed.
- Simultaneous events:
  - stop and completion in the same cycle: IDLE.
  - stop arriving during READ: the current generation's rows finish streaming first.
- Selector arithmetic wraps modulo ROWS. Counters never exceed their width.

Decomposition:
- Package life_ctrl_pkg holds the state enum, ROWS/COLS/SEL_W constants and the row-index type.
- One sub-module, life_tick_div: a loadable down-counter with a terminal-count pulse, used for the RUN delay.

Test Plan:
- Load a blinker (row 7 = 0x0380, others 0); start load_en=1, num_gens=2, tick_div=3 -> 16 write_enb pulses at selectors 0..15; step exactly 5 cycles after the last load; readout row 6/7/8 = 0x0100 in generation 1; gen_count=2; busy falls.
- Load a block (rows 4,5 = 0x0030); num_gens=0 -> after generation 1, stable=1 and the block returns to IDLE with gen_count=1.
- Hold out_ready=0 for 10 cycles mid-readout at row 5 -> out_data, out_row and valo_selector stay constant; no step pulse occurs.
- Free-run (num_gens=0) with a glider; pulse stop during RUN -> the current generation finishes all 16 rows, then IDLE; exactly one more step pulse is seen.
- Assert reset during LOAD after 8 rows -> all outputs are 0 the next cycle; no write_enb; a later start with load_en=1 begins again at row 0.
- start pulsed while busy -> ignored; tick_div=0 -> behaves as 1.
